rr_req_gather: RTL and testbench

Requester-side companion to the round-robin arbiter. It collects transactions from N client ports into small per-client FIFOs, and drives the arbiter's request vector. It consumes the arbiter's registered one-hot grant and moves the granted client's head entry into a shared output buffer with a valid/ready handshake. The request logic accounts for the arbiter's one-cycle grant latency, so a grant always finds data and output space.

---
 rtl/rr_req_gather.sv | 166 ++++++++++++++++
 tb/tb_rr_req_gather.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_gather.sv
// Gathers N client streams into per-client FIFOs, requests the round-robin arbiter and
// forwards granted heads into a 2-entry output buffer. Optional grant checking: RR_REQ_CHECK_EN.

module rr_req_cli_fifo #(
  parameter int W         = 32,
  parameter int CLI_DEPTH = 2,
  localparam int PW       = $clog2(CLI_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] cnt
);
  logic [W-1:0]  mem [CLI_DEPTH];
  logic [PW-1:0] wptr, rptr;

  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module rr_req_gather #(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int CLI_DEPTH = 2,
  localparam int IDW      = $clog2(N),
  localparam int CW       = $clog2(CLI_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     cli_valid,
  input  logic [N*W-1:0]   cli_data,
  output logic [N-1:0]     cli_ready,
  output logic [N-1:0]     arb_req,
  input  logic [N-1:0]     arb_grant,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [IDW-1:0]   out_id,
  input  logic             out_ready,
  output logic             err
);
  localparam logic [N-1:0]  ONE  = N'(1);
  localparam logic [CW-1:0] FULL = CW'(CLI_DEPTH);

  logic [N-1:0][W-1:0]  head;
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0]         nonempty, cli_push, cli_pop;

  logic           gnt_any, gnt_onehot, gnt_ok;
  logic [W-1:0]   sel_data;
  logic [IDW-1:0] sel_id;

  logic [W-1:0]   ob_data [2];
  logic [IDW-1:0] ob_id   [2];
  logic           ob_wptr, ob_rptr;
  logic [1:0]     out_cnt;
  logic           out_push, out_pop, req_gate;

  for (genvar i = 0; i < N; i++) begin : g_cli
    assign cli_ready[i] = (cnt[i] != FULL);
    assign nonempty[i]  = (cnt[i] != '0);
    assign cli_push[i]  = cli_valid[i] & cli_ready[i];
    assign cli_pop[i]   = arb_grant[i] & gnt_ok;
    // Last entry is not re-requested while its grant is in flight.
    assign arb_req[i]   = (cnt[i] > {{(CW-1){1'b0}}, arb_grant[i]}) & ~req_gate;

    rr_req_cli_fifo #(.W(W), .CLI_DEPTH(CLI_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cli_push[i]),
      .din   (cli_data[i*W +: W]),
      .pop   (cli_pop[i]),
      .head  (head[i]),
      .cnt   (cnt[i])
    );
  end

  assign gnt_any    = |arb_grant;
  assign gnt_onehot = gnt_any & ((arb_grant & (arb_grant - ONE)) == '0);
  assign out_valid  = (out_cnt != 2'd0);
  assign out_pop    = out_valid & out_ready;
  // Malformed grants, grants to empty clients and grants with no buffer room are dropped.
  assign gnt_ok     = gnt_onehot & |(arb_grant & nonempty) & ((out_cnt != 2'd2) | out_pop);
  assign out_push   = gnt_ok;
  assign req_gate   = ({1'b0, out_cnt} + {2'b00, gnt_any}) >= 3'd2;

  always_comb begin
    sel_data = '0;
    sel_id   = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) begin
        sel_data = head[i];
        sel_id   = IDW'(i);
      end
    end
  end

  assign out_data = ob_data[ob_rptr];
  assign out_id   = ob_id[ob_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      ob_data[0] <= '0;
      ob_data[1] <= '0;
      ob_id[0]   <= '0;
      ob_id[1]   <= '0;
      ob_wptr    <= 1'b0;
      ob_rptr    <= 1'b0;
      out_cnt    <= 2'd0;
    end else begin
      if (out_push) begin
        ob_data[ob_wptr] <= sel_data;
        ob_id[ob_wptr]   <= sel_id;
        ob_wptr          <= ~ob_wptr;
      end
      if (out_pop) ob_rptr <= ~ob_rptr;
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

`ifdef RR_REQ_CHECK_EN
  logic [N-1:0] req_q;
  logic         err_q, gnt_bad;

  assign gnt_bad = (gnt_any & ~gnt_onehot) | (|(arb_grant & ~req_q)) | (|(arb_grant & ~nonempty));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      err_q <= 1'b0;
    end else begin
      req_q <= arb_req;
      if (gnt_bad) err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rr_req_gather.sv
// Directed bench for rr_req_gather with a behavioural registered round-robin arbiter
// whose grant can be overridden to inject protocol violations.

module tb_rr_req_gather;
  localparam int N = 4;
  localparam int W = 32;
`ifdef RR_REQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   cli_valid;
  logic [N*W-1:0] cli_data;
  logic [N-1:0]   cli_ready;
  logic [N-1:0]   arb_req;
  logic [N-1:0]   arb_grant;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic           out_ready;
  logic           err;

  logic           force_en;
  logic [N-1:0]   force_grant;
  logic [N-1:0]   gnt_q, pick;
  logic [1:0]     ptr, pidx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_req_gather #(.N(N), .W(W), .CLI_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cli_valid (cli_valid),
    .cli_data  (cli_data),
    .cli_ready (cli_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .err       (err)
  );

  // Round-robin arbiter: registered one-hot grant, priority rotates past the last winner.
  always_comb begin
    pick = '0;
    pidx = ptr;
    for (int k = 0; k < N; k++) begin
      if (pick == '0 && arb_req[2'(ptr + 2'(k))]) begin
        pidx = 2'(ptr + 2'(k));
        pick = N'(1) << pidx;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      gnt_q <= '0;
      ptr   <= '0;
    end else begin
      gnt_q <= pick;
      if (pick != '0) ptr <= pidx + 2'd1;
    end
  end

  assign arb_grant = force_en ? force_grant : gnt_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cli_valid = '0;
    force_en  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_all(input logic [31:0] base, input int k);
    cli_valid = '1;
    for (int i = 0; i < N; i++) cli_data[i*W +: W] = base | 32'(i << 4) | 32'(k);
  endtask

  // Expects ids 0,1,2,3,0,1,2,3 carrying entry 0 then entry 1 of each client.
  task automatic collect(input logic [31:0] base);
    int n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      if (out_valid) begin
        chk($sformatf("rr_id%0d", n), 64'(out_id), 64'(n % 4));
        chk($sformatf("rr_data%0d", n), 64'(out_data), 64'(base | 32'((n % 4) << 4) | 32'(n / 4)));
        n++;
      end
      tick();
    end
    chk("drain_count", 64'(n), 64'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cli_data    = '0;
    out_ready   = 1'b0;
    force_grant = '0;
    do_reset();

    chk("rst_cli_ready", 64'(cli_ready), 64'hF);
    chk("rst_arb_req",   64'(arb_req),   64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_out_id",    64'(out_id),    64'h0);
    chk("rst_err",       64'(err),       64'h0);

    // Single transfer: client 2, three-edge latency to out_valid being sampled.
    out_ready = 1'b1;
    cli_valid = 4'b0100;
    cli_data[2*W +: W] = 32'hA5A5_0002;
    tick();
    cli_valid = '0;
    chk("single_req",      64'(arb_req),   64'h4);
    tick();
    chk("single_grant",    64'(arb_grant), 64'h4);
    chk("single_req_last", 64'(arb_req),   64'h0);
    chk("single_nv",       64'(out_valid), 64'h0);
    tick();
    chk("single_valid",    64'(out_valid), 64'h1);
    chk("single_id",       64'(out_id),    64'h2);
    chk("single_data",     64'(out_data),  64'hA5A5_0002);
    chk("single_empty",    64'(cli_ready), 64'hF);
    tick();
    chk("single_popped",   64'(out_valid), 64'h0);

    // All clients push two entries, consumer always ready.
    do_reset();
    out_ready = 1'b1;
    load_all(32'hC000_0000, 0);
    tick();
    load_all(32'hC000_0000, 1);
    tick();
    cli_valid = '0;
    collect(32'hC000_0000);
    chk("stream_idle_req", 64'(arb_req), 64'h0);

    // Backpressure: only two entries may enter the output buffer.
    do_reset();
    out_ready = 1'b0;
    load_all(32'hB000_0000, 0);
    tick();
    load_all(32'hB000_0000, 1);
    tick();
    cli_valid = '0;
    repeat (8) tick();
    chk("bp_req",       64'(arb_req),   64'h0);
    chk("bp_grant",     64'(arb_grant), 64'h0);
    chk("bp_valid",     64'(out_valid), 64'h1);
    chk("bp_id",        64'(out_id),    64'h0);
    chk("bp_data",      64'(out_data),  64'hB000_0000);
    chk("bp_cli_ready", 64'(cli_ready), 64'h3);
    out_ready = 1'b1;
    collect(32'hB000_0000);

    // Last-entry rule.
    do_reset();
    out_ready = 1'b0;
    cli_valid = 4'b0010;
    cli_data[1*W +: W] = 32'h1111_0001;
    tick();
    cli_valid = '0;
    chk("last_req",     64'(arb_req),   64'h2);
    tick();
    chk("last_grant",   64'(arb_grant), 64'h2);
    chk("last_req_off", 64'(arb_req),   64'h0);
    tick();
    chk("last_no_2nd",  64'(arb_grant), 64'h0);
    chk("last_empty",   64'(cli_ready), 64'hF);
    chk("last_valid",   64'(out_valid), 64'h1);
    chk("last_id",      64'(out_id),    64'h1);
    out_ready = 1'b1;
    tick();
    chk("last_drained", 64'(out_valid), 64'h0);

    // Protocol violations: multi-hot grant, then grant to an empty client.
    do_reset();
    out_ready   = 1'b1;
    force_en    = 1'b1;
    force_grant = 4'b0011;
    tick();
    force_grant = '0;
    chk("proto_mh_err",    64'(err),       64'(CHK));
    chk("proto_mh_nopush", 64'(out_valid), 64'h0);
    tick();
    tick();
    chk("proto_sticky",    64'(err),       64'(CHK));
    do_reset();
    chk("proto_rst_err",   64'(err),       64'h0);
    force_en    = 1'b1;
    force_grant = 4'b1000;
    tick();
    force_grant = '0;
    chk("proto_empty_err",    64'(err),       64'(CHK));
    chk("proto_empty_nopush", 64'(out_valid), 64'h0);
    chk("proto_empty_ready",  64'(cli_ready), 64'hF);

    // Reset mid-stream with three entries queued.
    do_reset();
    out_ready = 1'b0;
    cli_valid = 4'b0111;
    cli_data  = {32'h0, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    tick();
    cli_valid = '0;
    chk("mid_req", 64'(arb_req), 64'h7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_cli_ready", 64'(cli_ready), 64'hF);
    chk("mid_arb_req",   64'(arb_req),   64'h0);
    chk("mid_out_valid", 64'(out_valid), 64'h0);
    chk("mid_out_data",  64'(out_data),  64'h0);
    chk("mid_out_id",    64'(out_id),    64'h0);
    out_ready = 1'b1;
    cli_valid = 4'b1000;
    cli_data[3*W +: W] = 32'hE000_0003;
    tick();
    cli_valid = '0;
    tick();
    tick();
    chk("post_valid", 64'(out_valid), 64'h1);
    chk("post_id",    64'(out_id),    64'h3);
    chk("post_data",  64'(out_data),  64'hE000_0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
